garbage_insert: RTL and testbench
=================================

# garbage_insert

Sequential garbage-line inserter for the 20x20 Tetris playfield. It is the reverse of line clearing: it pushes N solid rows, each with one hole, into the bottom of the field and shifts the existing contents up. Rows pushed off the top are discarded and flagged as top-out. It sits between the game controller (attack and penalty logic) and the field register, and runs one row per clock.

## Interface
- ROWS, 20, playfield rows.
- COLS, 20, playfield columns; field width is ROWS*COLS = 400.
- MAX_LINES, 4, maximum rows inserted per request.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- lines  in  3  rows to insert; values above MAX_LINES are clipped to MAX_LINES.
- field_in  in  [0:399]  current field, captured when start is accepted.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse when field_out is updated.
- field_out  out  [0:399]  resulting field, held until the next completion.
- topout  out  1  a non-empty row was pushed off the top during the last request.

## Operation
- Field layout: row r occupies bits [20r : 20r+19]. Row 0 is the top row and row 19 the bottom row. Bit 20r is the leftmost column.
- Garbage row: all ones except a zero at column `hole`. One hole column is used for every row of a request.
- Hole source: an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1.
  - Seed 8'h01 on reset.
  - Advances every cycle in every state.
  - At start acceptance, h = lfsr[4:0] is latched; hole = h if h<20, else h-12.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1, clipped lines=0: go to DONE. work=field_in, topout cleared.
  - IDLE, start=1, lines≥1: work=field_in, cnt=clip(lines), hole latched, topout cleared, go to SHIFT.
  - SHIFT, each cycle:
    - If work row 0 != 0, set topout.
    - work <= {work[20:399], garbage_row}.
    - cnt <= cnt-1.
    - When cnt=1, go to DONE.
  - DONE: field_out <= work, done=1 for exactly this cycle, then go to IDLE.
- start while busy=1 is ignored; no queuing.
- The topout flag is sticky within a request. It is cleared only on accepting a new start or on reset.

## Timing
- Reset values: busy=0, done=0, field_out=0, topout=0, state IDLE, cnt=0, lfsr=8'h01.
- start accepted at edge k:
  - busy=1 from cycle k+1 through the DONE cycle inclusive.
  - The N shifts occur at edges k+1 … k+N.
  - DONE occupies cycle k+N+1. field_out and topout are valid from then on.
  - Total latency from start to done is N+1 cycles; N=0 gives 1 cycle.
- The next start can be accepted in the cycle after DONE, i.e. earliest at edge k+N+2.
- field_in is not required to stay stable after the acceptance edge.
- Reset mid-operation: the request is abandoned. All outputs return to reset values on the next edge, no done is emitted, and the partial work is discarded.
- Bottom rows inserted earlier in a request move up as later rows arrive. Final rows 20-N … 19 are all garbage with the same hole.

## Structure
- Shared package tetris_field_pkg holds:
  - ROWS, COLS, FIELD_W=400.
  - row_t (20-bit row type).
  - GARBAGE_LFSR_SEED=8'h01 and the tap mask.
  - The row-index helper used by the line-clear block.
- Sub-module garbage_lfsr holds the 8-bit LFSR plus the 0..19 hole mapping. It outputs `hole` (5 bits) and is reused by the piece randomizer later.
- Top level holds the FSM, cnt, work register and output registers.

## Test plan
- Reset, empty field, start with lines=1 in the first cycle after reset (lfsr=8'h01, hole=1) -> done at +2 cycles. Row 19 = 20'b1011_1111_1111_1111_1111; all other rows 0; topout=0.
- lines=7 on an empty field -> clipped to 4. done at +5 cycles. Rows 16-19 each equal the garbage row with an identical hole; rows 0-15 zero.
- Field with only row 0 = 20'h80000, lines=2 -> topout=1 at done. Row 0 content discarded; rows 18-19 garbage.
- Field with only row 2 = 20'hFFFFF, lines=2 -> topout=0. That row appears at row 0; rows 18-19 garbage.
- lines=0 with a random field_in -> done after 1 cycle. field_out equals field_in; topout=0.
- start pulsed while busy is ignored (exactly one done). Reset asserted mid-SHIFT -> no done; outputs 0 the next cycle.

Source files
------------

// File: rtl/tetris_field_pkg.sv
// Shared playfield geometry, garbage-hole LFSR constants and the FSM state type
// used by the garbage inserter.
package tetris_field_pkg;
  localparam int ROWS      = 20;
  localparam int COLS      = 20;
  localparam int FIELD_W   = ROWS * COLS;
  localparam int MAX_LINES = 4;

  typedef logic [COLS-1:0] row_t;

  // x^8+x^6+x^5+x^4+1 as a mask over lfsr bits [7,5,4,3]
  localparam logic [7:0] GARBAGE_LFSR_SEED = 8'h01;
  localparam logic [7:0] GARBAGE_LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } gi_state_e;

  // First bit of row r inside the flat field vector (row 0 is the top row).
  function automatic int unsigned row_lsb(input int unsigned r);
    return r * COLS;
  endfunction
endpackage

// File: rtl/garbage_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; its low five bits are folded into a
// playfield column 0..19 to pick the garbage hole.
module garbage_lfsr
  import tetris_field_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] hole
);
  logic [7:0] lfsr_q;
  logic [4:0] h;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= GARBAGE_LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & GARBAGE_LFSR_TAPS)};
  end

  // 20..31 fold onto 8..19 so every value lands on a real column
  assign h    = lfsr_q[4:0];
  assign hole = (h < 5'd20) ? h : h - 5'd12;
endmodule

// File: rtl/garbage_insert.sv
// Pushes up to MAX_LINES holed garbage rows into the bottom of the playfield,
// one row per clock, flagging top-out when a non-empty row falls off the top.
module garbage_insert
  import tetris_field_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         lines,
  input  logic [0:FIELD_W-1] field_in,
  output logic               busy,
  output logic               done,
  output logic [0:FIELD_W-1] field_out,
  output logic               topout
);
  gi_state_e          state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [4:0]         hole_q, hole_d;
  logic [0:FIELD_W-1] work_q, work_d;
  logic [0:FIELD_W-1] field_q, field_d;
  logic               topout_q, topout_d;

  logic [4:0]         lfsr_hole;
  logic [2:0]         lines_clip;
  row_t               garb_row;
  logic [0:FIELD_W-1] shifted;

  garbage_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .hole  (lfsr_hole)
  );

  // Column c maps to row bit COLS-1-c, so column 0 is the row MSB.
  genvar gi;
  for (gi = 0; gi < COLS; gi++) begin : g_garb
    assign garb_row[COLS-1-gi] = (hole_q != 5'(gi));
  end

  assign lines_clip = (lines > 3'(MAX_LINES)) ? 3'(MAX_LINES) : lines;
  assign shifted    = {work_q[row_lsb(1):FIELD_W-1], garb_row};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hole_d   = hole_q;
    work_d   = work_q;
    field_d  = field_q;
    topout_d = topout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d   = field_in;
          hole_d   = lfsr_hole;
          topout_d = 1'b0;
          if (lines_clip == 3'd0) begin
            field_d = field_in;
            state_d = ST_DONE;
          end else begin
            cnt_d   = lines_clip;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (work_q[row_lsb(0) +: COLS] != '0) topout_d = 1'b1;
        work_d = shifted;
        cnt_d  = cnt_q - 3'd1;
        // Result is published on entry to DONE so it is valid while done is high.
        if (cnt_q == 3'd1) begin
          field_d = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hole_q   <= '0;
      work_q   <= '0;
      field_q  <= '0;
      topout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hole_q   <= hole_d;
      work_q   <= work_d;
      field_q  <= field_d;
      topout_q <= topout_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign field_out = field_q;
  assign topout    = topout_q;
endmodule

// File: tb/tb_garbage_insert.sv
// Scoreboard bench for garbage_insert: requests push expected results, a
// negedge monitor checks field_out/topout/latency whenever done pulses.
module tb_garbage_insert;
  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   lines;
  logic [0:399] field_in;
  logic         busy, done, topout;
  logic [0:399] field_out;

  garbage_insert dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lines     (lines),
    .field_in  (field_in),
    .busy      (busy),
    .done      (done),
    .field_out (field_out),
    .topout    (topout)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          done_cnt = 0;
  int          exp_dones = 0;
  longint      cyc = 0;
  logic [7:0]  lfsr_m;

  typedef struct {
    logic [0:399] f;
    logic         to;
    longint       at;
  } exp_t;
  exp_t sb[$];

  // Reference hole generator: x^8+x^6+x^5+x^4+1, seed 01, steps every cycle
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= reset ? 8'h01 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check(input string name, input logic [399:0] got, input logic [399:0] expv);
    checks++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  function automatic void model(input logic [0:399] f, input int n, input int hole,
                                output logic [0:399] r, output logic to);
    logic [19:0] g;
    g = '1;
    g[19-hole] = 1'b0;
    to = 1'b0;
    r = f;
    for (int i = 0; i < n; i++) begin
      if (r[0:19] != 20'd0) to = 1'b1;
      r = {r[20:399], g};
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        check("field_out", field_out, e.f);
        check("topout", topout, e.to);
        check("done_cycle", cyc, e.at);
        $display("done at cycle %0d topout=%0b", cyc, topout);
      end
    end
  end

  // Drives a request at the current negedge; returns at a negedge with the DUT idle.
  task automatic do_req(input logic [0:399] f, input int nl, input bit poke);
    int n, h, hole;
    logic [0:399] r;
    logic to;
    n    = (nl > 4) ? 4 : nl;
    h    = int'(lfsr_m[4:0]);
    hole = (h < 20) ? h : h - 12;
    model(f, n, hole, r, to);
    sb.push_back('{f: r, to: to, at: cyc + 1 + n});
    exp_dones++;
    $display("req lines=%0d hole=%0d expect topout=%0b", nl, hole, to);
    start = 1'b1; lines = 3'(nl); field_in = f;
    @(negedge clk);
    start = 1'b0; field_in = {13{32'hDEADBEEF}};
    check("busy_after_accept", busy, 1'b1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; lines = 3'd1; field_in = '1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL done_timeout: no done within 20 cycles, required one");
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [0:399] rand_field();
    logic [0:399] f;
    for (int r = 0; r < 20; r++) f[r*20 +: 20] = 20'($urandom);
    return f;
  endfunction

  initial begin
    logic [0:399] f;
    reset = 1'b1; start = 1'b0; lines = 3'd0; field_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_field_out", field_out, 400'd0);
    check("reset_topout", topout, 1'b0);
    reset = 1'b0;

    // First cycle after reset: lfsr=01 so hole=1
    do_req('0, 1, 1'b0);
    check("row19_hole1", field_out[380 +: 20], 20'hBFFFF);
    check("row18_empty", field_out[360 +: 20], 20'h00000);

    do_req('0, 7, 1'b0);
    check("row16_eq_row19", field_out[320 +: 20], field_out[380 +: 20]);
    check("row15_empty", field_out[300 +: 20], 20'h00000);

    f = '0; f[0 +: 20] = 20'h80000;
    do_req(f, 2, 1'b0);
    check("topout_hand", topout, 1'b1);

    f = '0; f[40 +: 20] = 20'hFFFFF;
    do_req(f, 2, 1'b0);
    check("row0_from_row2", field_out[0 +: 20], 20'hFFFFF);

    f = rand_field();
    do_req(f, 0, 1'b0);
    check("lines0_passthru", field_out, f);

    do_req(rand_field(), 4, 1'b1);

    for (int i = 0; i < 6; i++) begin
      repeat (i * 3 + 1) @(negedge clk);
      do_req(rand_field(), 1 + (i % 4), 1'b0);
    end

    // Abandon a request mid-SHIFT with reset
    start = 1'b1; lines = 3'd3; field_in = rand_field();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_field_out", field_out, 400'd0);
    check("midreset_topout", topout, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    do_req('0, 1, 1'b0);
    check("done_count", done_cnt, exp_dones);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
